// File: rtl/trigger_pulse_gen_pkg.sv
// Shared trigger definitions: FSM state encoding and idle line levels,
// common to the pulse generator and the trigger receivers.
package trigger_pulse_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_GAP    = 2'd2,
    ST_FINISH = 2'd3
  } trig_state_e;

  localparam logic TRIG_A_IDLE = 1'b0;
  localparam logic TRIG_B_IDLE = 1'b1;

endpackage

// File: rtl/trigger_pulse_gen_phase_timer.sv
// Loadable down-counter that holds at zero; expiry flags the last cycle of a phase.
module trig_phase_timer #(
  parameter int unsigned W = 16
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired_c
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign expired_c = (cnt_q == '0);

endmodule

// File: rtl/trigger_pulse_gen.sv
// Burst trigger generator: Pulse_Count events on line A (rising) and/or B (falling),
// each event High_Len active clocks followed by Low_Len idle clocks.
module trigger_pulse_gen
  import trigger_pulse_gen_pkg::*;
#(
  parameter int unsigned LEN_W = 16,
  parameter int unsigned CNT_W = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Abort,
  input  logic [CNT_W-1:0] Pulse_Count,
  input  logic [LEN_W-1:0] High_Len,
  input  logic [LEN_W-1:0] Low_Len,
  input  logic [1:0]       Line_Sel,
  output logic             Trig_Aout,
  output logic             Trig_Bout,
  output logic             Busy,
  output logic             Done,
  output logic             Aborted
);

  trig_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [LEN_W-1:0] hi_q, lo_q;
  logic [1:0]       sel_q;

  logic             latch, abort_hit, expired_c, phase_load;
  logic [LEN_W-1:0] load_val;
  logic [1:0]       sel_d;
  logic             a_d, b_d, busy_d, done_d, aborted_d;

  function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] v);
    return (v == '0) ? LEN_W'(1) : v;
  endfunction

  assign latch     = (state_q == ST_IDLE) && Start;
  assign abort_hit = Abort && ((state_q == ST_ACTIVE) || (state_q == ST_GAP));

  // State and registered outputs; outputs track the state they accompany.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      Trig_Aout <= TRIG_A_IDLE;
      Trig_Bout <= TRIG_B_IDLE;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Aborted   <= 1'b0;
    end else begin
      state_q   <= state_d;
      Trig_Aout <= a_d;
      Trig_Bout <= b_d;
      Busy      <= busy_d;
      Done      <= done_d;
      Aborted   <= aborted_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (Start) state_d = (Pulse_Count == '0) ? ST_FINISH : ST_ACTIVE;
      ST_ACTIVE: if (Abort) state_d = ST_IDLE;
                 else if (expired_c) state_d = ST_GAP;
      ST_GAP:    if (Abort) state_d = ST_IDLE;
                 else if (expired_c) state_d = (cnt_q != '0) ? ST_ACTIVE : ST_FINISH;
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sel_d     = latch ? Line_Sel : sel_q;
    a_d       = TRIG_A_IDLE;
    b_d       = TRIG_B_IDLE;
    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_d == ST_FINISH);
    aborted_d = abort_hit;
    if (state_d == ST_ACTIVE) begin
      a_d = sel_d[0];
      b_d = ~sel_d[1];
    end
  end

  // Latched burst parameters and pulse counter (saturates at zero).
  always_ff @(posedge Clock) begin
    if (Reset) begin
      cnt_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      sel_q <= '0;
    end else if (latch) begin
      cnt_q <= Pulse_Count;
      hi_q  <= eff_len(High_Len);
      lo_q  <= eff_len(Low_Len);
      sel_q <= Line_Sel;
    end else if ((state_q == ST_ACTIVE) && (state_d == ST_GAP) && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // The first ACTIVE phase loads from the live inputs since they latch on the same edge.
  assign phase_load = ((state_d == ST_ACTIVE) || (state_d == ST_GAP)) && (state_d != state_q);
  always_comb begin
    if (state_d == ST_ACTIVE) begin
      load_val = (latch ? eff_len(High_Len) : hi_q) - LEN_W'(1);
    end else begin
      load_val = lo_q - LEN_W'(1);
    end
  end

  trig_phase_timer #(.W(LEN_W)) u_timer (
    .Clock     (Clock),
    .Reset     (Reset),
    .load      (phase_load),
    .load_val  (load_val),
    .expired_c (expired_c)
  );

endmodule
